// File: rtl/riscv_mem_pkg.sv
// rtl/riscv_mem_pkg.sv - funct3 codes, LSU FSM encoding and request error checks
package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE,
    ST_RMW_RD,
    ST_RMW_WR,
    ST_RESP
  } lsu_state_t;

  typedef struct packed {
    logic misaligned;
    logic illegal;
    logic out_of_range;
  } lsu_err_t;

  // Misalignment is only reported for a legal funct3, so each fault has one cause.
  function automatic lsu_err_t lsu_check(input logic we, input logic [2:0] f3,
                                         input logic [1:0] lane, input logic oor);
    lsu_err_t e;
    e.illegal      = we ? !(f3 inside {F3_B, F3_H, F3_W})
                        : !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    e.misaligned   = !e.illegal &&
                     ((((f3 == F3_H) || (f3 == F3_HU)) && lane[0]) ||
                      ((f3 == F3_W) && (lane != 2'b00)));
    e.out_of_range = oor;
    return e;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - little-endian load extraction and sub-word store merge
module lsu_align
  import riscv_mem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_lane,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[7:0];
    case (i_lane)
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      2'd3:    w_byte = i_word[31:24];
      default: w_byte = i_word[7:0];
    endcase
    w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];

    o_load = '0;
    case (i_funct3)
      F3_B:    o_load = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_load = {24'h0, w_byte};
      F3_H:    o_load = {{16{w_half[15]}}, w_half};
      F3_HU:   o_load = {16'h0, w_half};
      F3_W:    o_load = i_word;
      default: o_load = '0;
    endcase

    o_merged = i_word;
    case (i_funct3)
      F3_B: o_merged[{i_lane, 3'b000} +: 8] = i_wdata[7:0];
      F3_H: begin
        if (i_lane[1]) o_merged[31:16] = i_wdata[15:0];
        else           o_merged[15:0]  = i_wdata[15:0];
      end
      default: o_merged = i_wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit in front of a word-wide async-read DataM
module load_store_unit
  import riscv_mem_pkg::*;
#(
  parameter int MEM_WORDS = 64,
  parameter int DATA_W    = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  lsu_state_t        r_state;
  lsu_state_t        w_next;
  logic [31:0]       r_a;
  logic [2:0]        r_f;
  logic [DATA_W-1:0] r_w;
  logic              r_s;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;
  logic [DATA_W-1:0] r_mem_wdata;

  lsu_err_t          w_err;
  logic              w_any_err;
  logic              w_oor;
  logic [DATA_W-1:0] w_load_data;
  logic [DATA_W-1:0] w_merged;

  assign w_oor     = (req_addr[31:2] >= 30'(MEM_WORDS));
  assign w_err     = lsu_check(req_we, req_funct3, req_addr[1:0], w_oor);
  assign w_any_err = |w_err;

  lsu_align u_align (
    .i_word   (mem_rdata),
    .i_wdata  (r_w),
    .i_funct3 (r_f),
    .i_lane   (r_a[1:0]),
    .o_load   (w_load_data),
    .o_merged (w_merged)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_we    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = RST;
        if (req_valid) begin
          if (w_any_err)                 w_next = ST_RESP;
          else if (!req_we)              w_next = ST_LOAD;
          else if (req_funct3 == F3_W)   w_next = ST_WRITE;
          else                           w_next = ST_RMW_RD;
        end
      end
      ST_LOAD:   w_next = ST_RESP;
      ST_WRITE: begin
        mem_we = 1'b1;
        w_next = ST_RESP;
      end
      ST_RMW_RD: w_next = ST_RMW_WR;
      ST_RMW_WR: begin
        mem_we = 1'b1;
        w_next = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        w_next    = ST_IDLE;
      end
      default:   w_next = ST_IDLE;
    endcase
  end

  // Captured request fields only change on accept, so they hold for the whole operation.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_a         <= '0;
      r_f         <= '0;
      r_w         <= '0;
      r_s         <= 1'b0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_a     <= req_addr;
            r_f     <= req_funct3;
            r_w     <= req_wdata;
            r_s     <= req_we;
            r_err   <= w_any_err;
            r_rdata <= '0;
            if (req_we && !w_any_err) r_mem_wdata <= req_wdata;
          end
        end
        ST_LOAD:   r_rdata     <= r_s ? '0 : w_load_data;
        ST_RMW_RD: r_mem_wdata <= w_merged;
        default: ;
      endcase
    end
  end

  assign mem_addr  = {r_a[31:2], 2'b00};
  assign mem_wdata = r_mem_wdata;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit with a DataM model
module tb_load_store_unit;
  import riscv_mem_pkg::*;

  localparam int MEM_WORDS = 64;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  logic [31:0] mem [MEM_WORDS];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int we_count = 0;
  int last_we_cyc = -1;

  load_store_unit #(.MEM_WORDS(MEM_WORDS), .DATA_W(32)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  always #5 CLK = ~CLK;

  assign mem_rdata = (mem_addr[31:8] == 24'h0) ? mem[mem_addr[7:2]] : 32'h0;

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (mem_we) begin
      we_count++;
      last_we_cyc = cyc;
      chk("mem_addr word aligned", {30'h0, mem_addr[1:0]}, 32'h0);
    end
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected rsp_valid", 32'h1, 32'h0);
      end else begin
        e = sb.pop_front();
        chk({e.nm, " rdata"}, rsp_rdata, e.rdata);
        chk({e.nm, " err"}, {31'h0, rsp_err}, {31'h0, e.err});
        chk({e.nm, " latency"}, 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic do_req(input string nm, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err,
                        input int lat, input int we_off);
    int acc;
    int we_base;
    int t;
    @(negedge CLK);
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    t = 0;
    while (!req_ready && t < 20) begin @(negedge CLK); t++; end
    if (!req_ready) begin
      chk({nm, " accept timeout"}, 32'h0, 32'h1);
      req_valid = 1'b0;
      return;
    end
    acc = cyc;
    we_base = we_count;
    sb.push_back('{exp_rd, exp_err, acc + lat, nm});
    @(posedge CLK);
    #1;
    req_valid = 1'b0; req_addr = 32'hFFFF_FFFC; req_wdata = 32'h0BAD_0BAD;
    req_we = ~we; req_funct3 = ~f3;
    t = 0;
    while (sb.size() != 0 && t < 20) begin @(negedge CLK); t++; end
    if (sb.size() != 0) begin
      chk({nm, " response timeout"}, 32'h0, 32'h1);
      sb.delete();
    end
    @(negedge CLK);
    chk({nm, " write count"}, 32'(we_count - we_base), (we_off >= 0) ? 32'h1 : 32'h0);
    if (we_off >= 0) chk({nm, " write cycle"}, 32'(last_we_cyc), 32'(acc + we_off));
  endtask

  logic [31:0] hv_addr [3];
  logic [2:0]  hv_f3   [3];
  logic [31:0] hv_exp  [3];
  int          hacc    [3];

  initial begin
    int t;
    int we_base;
    hv_addr[0] = 32'h10; hv_f3[0] = F3_W;  hv_exp[0] = 32'h8001BEEF;
    hv_addr[1] = 32'h12; hv_f3[1] = F3_BU; hv_exp[1] = 32'h00000001;
    hv_addr[2] = 32'h22; hv_f3[2] = F3_H;  hv_exp[2] = 32'h00001122;

    @(negedge CLK);
    chk("reset req_ready", {31'h0, req_ready}, 32'h0);
    chk("reset rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("reset rsp_err", {31'h0, rsp_err}, 32'h0);
    chk("reset rsp_rdata", rsp_rdata, 32'h0);
    chk("reset mem_we", {31'h0, mem_we}, 32'h0);
    chk("reset mem_addr", mem_addr, 32'h0);
    chk("reset mem_wdata", mem_wdata, 32'h0);
    RST = 1'b1;
    #1;
    chk("ready after reset", {31'h0, req_ready}, 32'h1);

    do_req("SW 0x10", 1'b1, F3_W, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1);
    chk("mem word4 after SW", mem[4], 32'hDEADBEEF);
    do_req("LW 0x10", 1'b0, F3_W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, -1);
    do_req("SB 0x12", 1'b1, F3_B, 32'h12, 32'h00000055, 32'h0, 1'b0, 3, 2);
    chk("mem word4 after SB", mem[4], 32'hDE55BEEF);
    do_req("LB 0x12", 1'b0, F3_B, 32'h12, 32'h0, 32'h00000055, 1'b0, 2, -1);
    do_req("LBU 0x13", 1'b0, F3_BU, 32'h13, 32'h0, 32'h000000DE, 1'b0, 2, -1);
    do_req("LB 0x13", 1'b0, F3_B, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0, 2, -1);
    do_req("LB 0x11", 1'b0, F3_B, 32'h11, 32'h0, 32'hFFFFFFBE, 1'b0, 2, -1);
    do_req("LHU 0x10", 1'b0, F3_HU, 32'h10, 32'h0, 32'h0000BEEF, 1'b0, 2, -1);
    do_req("SH 0x12", 1'b1, F3_H, 32'h12, 32'h00008001, 32'h0, 1'b0, 3, 2);
    chk("mem word4 after SH", mem[4], 32'h8001BEEF);
    do_req("LH 0x12", 1'b0, F3_H, 32'h12, 32'h0, 32'hFFFF8001, 1'b0, 2, -1);
    do_req("LHU 0x12", 1'b0, F3_HU, 32'h12, 32'h0, 32'h00008001, 1'b0, 2, -1);

    do_req("LW misaligned 0x11", 1'b0, F3_W, 32'h11, 32'h0, 32'h0, 1'b1, 1, -1);
    do_req("SH misaligned 0x13", 1'b1, F3_H, 32'h13, 32'h1234, 32'h0, 1'b1, 1, -1);
    do_req("load funct3 011", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1, -1);
    do_req("store funct3 100", 1'b1, 3'b100, 32'h10, 32'h77777777, 32'h0, 1'b1, 1, -1);
    do_req("LW out of range", 1'b0, F3_W, 32'(MEM_WORDS * 4), 32'h0, 32'h0, 1'b1, 1, -1);
    chk("mem word4 after errors", mem[4], 32'h8001BEEF);

    do_req("SW 0x20", 1'b1, F3_W, 32'h20, 32'h11223344, 32'h0, 1'b0, 2, 1);
    chk("mem word8 after SW", mem[8], 32'h11223344);

    // Reset lands while the SB is in its read half; nothing may reach DataM.
    @(negedge CLK);
    req_we = 1'b1; req_funct3 = F3_B; req_addr = 32'h20; req_wdata = 32'hAA; req_valid = 1'b1;
    t = 0;
    while (!req_ready && t < 20) begin @(negedge CLK); t++; end
    chk("reset-test accept", {31'h0, req_ready}, 32'h1);
    we_base = we_count;
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("ready while reset low", {31'h0, req_ready}, 32'h0);
    chk("mem_we while reset low", {31'h0, mem_we}, 32'h0);
    @(negedge CLK);
    chk("ready still low", {31'h0, req_ready}, 32'h0);
    RST = 1'b1;
    #1;
    chk("ready after mid-op reset", {31'h0, req_ready}, 32'h1);
    repeat (4) @(negedge CLK);
    chk("mem word8 after aborted SB", mem[8], 32'h11223344);
    chk("no write after aborted SB", 32'(we_count - we_base), 32'h0);

    @(negedge CLK);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = hv_f3[0]; req_addr = hv_addr[0]; req_wdata = 32'h0;
    for (int v = 0; v < 3; v++) begin
      t = 0;
      while (!req_ready && t < 20) begin @(negedge CLK); t++; end
      if (!req_ready) begin
        chk("hold accept timeout", 32'h0, 32'h1);
        break;
      end
      hacc[v] = cyc;
      sb.push_back('{hv_exp[v], 1'b0, cyc + 2, $sformatf("hold load %0d", v)});
      if (v > 0) chk("hold accept spacing", 32'(hacc[v] - hacc[v-1]), 32'd3);
      @(posedge CLK);
      #1;
      if (v < 2) begin
        req_funct3 = hv_f3[v+1]; req_addr = hv_addr[v+1];
      end else begin
        req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_funct3 = 3'b111;
      end
      @(negedge CLK);
      chk("ready low in LOAD", {31'h0, req_ready}, 32'h0);
      @(negedge CLK);
      chk("ready low in RESP", {31'h0, req_ready}, 32'h0);
    end
    t = 0;
    while (sb.size() != 0 && t < 20) begin @(negedge CLK); t++; end
    if (sb.size() != 0) chk("hold response timeout", 32'h0, 32'h1);
    repeat (2) @(negedge CLK);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
